mtm_alu_deserializer: RTL and testbench
=======================================

Name: mtm_alu_deserializer

Overview:
- Serial receiver that sits directly upstream of the ALU core.
- Decodes the 1-bit serial input line `sin` into 11-bit frames and assembles each packet of 8 data frames plus 1 command frame.
- Checks packet length, CRC4 and opcode.
- Presents parallel B, A, OP with a one-cycle valid strobe, or a one-hot error flag set with an error strobe, to the core.

Parameters:
- DATA_FRAMES, 8, number of data frames per packet: B[31:24] first, through B[7:0], then A[31:24] through A[7:0].

Ports:
- clk  in  1  clock; one serial bit is sampled per rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- sin  in  1  serial input; idles high.
- a_out  out  32  operand A.
- b_out  out  32  operand B.
- op_out  out  3  opcode.
- out_valid  out  1  one-cycle strobe: a_out, b_out and op_out are valid.
- err_out  out  1  one-cycle strobe: packet rejected.
- err_flags  out  3  {ERR_DATA, ERR_CRC, ERR_OP}; exactly one bit is set when err_out=1.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM goes to IDLE.
  - Frame counter, bit counter and shift registers are cleared.
  - Reset asserted mid-packet discards the partial packet; no strobe is generated.
- Frame format (11 bits, MSB first): start=0, type (0=data, 1=cmd), d[7:0], stop=1.
- FSM states:
  - IDLE: go to TYPE when sin=0.
  - TYPE: latch the type bit, go to BITS.
  - BITS: shift 8 bits, counter 7..0; at 0 go to STOP.
  - STOP: evaluate the frame.
    - sin=1: go to IDLE.
    - sin=0: framing error; go to DRAIN.
  - DRAIN: wait for sin=1, then go to IDLE.
- Frames may be back-to-back: a start bit may occur on the cycle right after a stop bit.
- Data frame with good stop bit:
  - Shift the byte into a 64-bit {B,A} register.
  - Increment the data-frame count, saturating at DATA_FRAMES+1.
- Command frame with good stop bit: cmd byte = {1'b0, OP[2:0], CRC[3:0]}. Evaluate in priority order:
  1. count != DATA_FRAMES → ERR_DATA.
  2. Received CRC != crc4({B, A, 1'b1, OP}) → ERR_CRC.
  3. OP not in {000 AND, 001 OR, 100 ADD, 101 SUB} → ERR_OP.
  4. Otherwise: load a_out, b_out, op_out and pulse out_valid.
- After any command frame (good or error) the data-frame count is cleared.
- Framing error (stop bit 0) in any frame:
  - Pulse err_out with ERR_DATA.
  - Clear the count.
  - Discard the partial packet.
- CRC4:
  - Polynomial x^4+x+1, init 0000.
  - 68 input bits, first bit = B[31].
  - Serial update: fb = crc[3]^d; crc = {crc[2:0],1'b0} ^ (fb ? 4'b0011 : 0).
  - May be computed incrementally as bits arrive or in parallel at the command frame; the results must be identical.
- Latency:
  - Outputs and strobes are registered on the same edge that samples the command stop bit.
  - The strobe is high for exactly the following cycle.
  - a_out, b_out and op_out hold their value until the next valid packet.
  - err_flags returns to 000 when err_out deasserts.
- Extra data frames (a 9th or later before a command): no immediate error; the packet reports ERR_DATA at its command frame.
- A command frame with zero data frames reports ERR_DATA.
- out_valid and err_out are never asserted in the same cycle.

Decomposition:
- Shared package mtm_alu_pkg holds:
  - Opcode constants: AND=3'b000, OR=3'b001, ADD=3'b100, SUB=3'b101.
  - Error-flag bit indices.
  - Frame type constants: DATA=0, CMD=1.
  - Function crc4_d68 (also used by the verification model).
  - FSM state enum.
- One sub-module: mtm_alu_frame_rx (bit-level FSM). It outputs byte, type, frame_ok and frame_err strobes. The packet/CRC checker lives in the top.

Test Plan:
- A=0, B=0, 8 data frames of 0x00, cmd 0x0B (OP=000, CRC=1011) → out_valid pulse; a_out=0, b_out=0, op_out=000; err_out=0.
- B=0x01020304, A=0x05060708, OP=100 (ADD), correct CRC, frames back-to-back with no idle gap → out_valid; b_out=0x01020304, a_out=0x05060708, op_out=100.
- Same zero packet with cmd 0x0A (bad CRC) → err_out pulse, err_flags=010, out_valid=0, a_out/b_out unchanged.
- Zero operands, cmd 0x2D (OP=010, CRC=1101 correct) → err_flags=001 (ERR_OP).
- 7 data frames then cmd, and separately 9 data frames then cmd → err_flags=100 (ERR_DATA) in both cases. A following well-formed packet is then accepted normally.
- Stop bit forced to 0 in data frame 3 → immediate err_flags=100. Holding sin low for 20 cycles produces no further strobes. The next packet after sin returns high is accepted. rst_n low mid-packet → all outputs 0, no strobe.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg: definitions shared by the ALU serial receiver and its bench.
//   - opcode constants and an opcode legality check
//   - error-flag bit indices into err_flags[2:0] = {ERR_DATA, ERR_CRC, ERR_OP}
//   - frame type constants
//   - crc4_d68: CRC4 (x^4+x+1, init 0) over {B, A, 1'b1, OP}, B[31] first
//   - bit-level receiver state enum
package mtm_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    localparam int unsigned ERR_DATA = 2;
    localparam int unsigned ERR_CRC  = 1;
    localparam int unsigned ERR_OP   = 0;

    localparam logic FT_DATA = 1'b0;
    localparam logic FT_CMD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TYPE,
        ST_BITS,
        ST_STOP,
        ST_DRAIN
    } rx_state_t;

    function automatic logic op_valid(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] crc4_d68(input logic [67:0] d);
        logic [3:0]  c;
        logic [67:0] s;
        logic        fb;
        c = '0;
        s = d;
        for (int unsigned i = 0; i < 68; i++) begin
            fb = c[3] ^ s[67];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
            s  = {s[66:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/mtm_alu_deserializer_if.sv
// mtm_alu_deserializer_if: serial input and parallel result bus of the
// receiver.
//   sin        serial line into the receiver (idles high)
//   a_out      operand A          b_out     operand B
//   op_out     opcode             out_valid one-cycle result strobe
//   err_out    one-cycle reject strobe
//   err_flags  {ERR_DATA, ERR_CRC, ERR_OP}, one-hot while err_out=1
// master: the receiver side; slave: the line driver / ALU core side.
interface mtm_alu_deserializer_if;
    logic        sin;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [2:0]  op_out;
    logic        out_valid;
    logic        err_out;
    logic [2:0]  err_flags;

    modport master (
        input  sin,
        output a_out, b_out, op_out, out_valid, err_out, err_flags
    );

    modport slave (
        output sin,
        input  a_out, b_out, op_out, out_valid, err_out, err_flags
    );
endinterface

// File: rtl/mtm_alu_frame_rx.sv
// mtm_alu_frame_rx: bit-level receiver for 11-bit frames
// {start=0, type, d[7:0], stop=1}, MSB first, one bit per rising clk.
//   clk, rst_n  clock, synchronous active-low reset
//   sin         serial input
//   rx_byte     received data byte (valid while frame_ok/frame_err)
//   frame_type  received type bit (FT_DATA / FT_CMD)
//   frame_ok    high in the stop-bit cycle when the stop bit is 1
//   frame_err   high in the stop-bit cycle when the stop bit is 0
module mtm_alu_frame_rx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin,
    output logic [7:0] rx_byte,
    output logic       frame_type,
    output logic       frame_ok,
    output logic       frame_err
);

    rx_state_t  state;
    logic [2:0] bit_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            rx_byte    <= '0;
            frame_type <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:  if (!sin) state <= ST_TYPE;
                ST_TYPE: begin
                    frame_type <= sin;
                    bit_cnt    <= 3'd7;
                    state      <= ST_BITS;
                end
                ST_BITS: begin
                    rx_byte <= {rx_byte[6:0], sin};
                    bit_cnt <= bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) state <= ST_STOP;
                end
                ST_STOP:  state <= sin ? ST_IDLE : ST_DRAIN;
                ST_DRAIN: if (sin) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode the stop-bit cycle directly so the packet checker can
    // register its result on the very edge that samples the stop bit.
    assign frame_ok  = (state == ST_STOP) &&  sin;
    assign frame_err = (state == ST_STOP) && !sin;

endmodule

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: serial packet receiver upstream of the ALU core.
// A packet is DATA_FRAMES data frames (B[31:24] first ... A[7:0] last)
// followed by one command frame {1'b0, OP[2:0], CRC[3:0]}.
//   clk, rst_n  clock, synchronous active-low reset
//   bus         master side of mtm_alu_deserializer_if (sin in; a_out,
//               b_out, op_out, out_valid, err_out, err_flags out)
// Rejects report exactly one of ERR_DATA (count or framing), ERR_CRC,
// ERR_OP, checked in that priority order.
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
#(
    parameter int unsigned DATA_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mtm_alu_deserializer_if.master bus
);

    localparam int unsigned CW = $clog2(DATA_FRAMES + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_FRAMES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DATA_FRAMES + 1);

    logic [7:0]    rx_byte;
    logic          frame_type;
    logic          frame_ok;
    logic          frame_err;
    logic [63:0]   ba_shreg;
    logic [CW-1:0] data_cnt;
    logic [2:0]    cmd_op;
    logic [3:0]    cmd_crc;
    logic [3:0]    calc_crc;

    mtm_alu_frame_rx u_frame_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (bus.sin),
        .rx_byte    (rx_byte),
        .frame_type (frame_type),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err)
    );

    assign cmd_op   = rx_byte[6:4];
    assign cmd_crc  = rx_byte[3:0];
    assign calc_crc = crc4_d68({ba_shreg, 1'b1, cmd_op});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ba_shreg      <= '0;
            data_cnt      <= '0;
            bus.a_out     <= '0;
            bus.b_out     <= '0;
            bus.op_out    <= '0;
            bus.out_valid <= 1'b0;
            bus.err_out   <= 1'b0;
            bus.err_flags <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.err_out   <= 1'b0;
            bus.err_flags <= '0;
            if (frame_err) begin
                bus.err_out             <= 1'b1;
                bus.err_flags[ERR_DATA] <= 1'b1;
                data_cnt                <= '0;
                ba_shreg                <= '0;
            end else if (frame_ok) begin
                if (frame_type == FT_DATA) begin
                    ba_shreg <= {ba_shreg[55:0], rx_byte};
                    if (data_cnt != CNT_MAX) data_cnt <= data_cnt + 1'b1;
                end else begin
                    data_cnt <= '0;
                    if (data_cnt != CNT_FULL) begin
                        bus.err_out             <= 1'b1;
                        bus.err_flags[ERR_DATA] <= 1'b1;
                    end else if (cmd_crc != calc_crc) begin
                        bus.err_out            <= 1'b1;
                        bus.err_flags[ERR_CRC] <= 1'b1;
                    end else if (!op_valid(cmd_op)) begin
                        bus.err_out           <= 1'b1;
                        bus.err_flags[ERR_OP] <= 1'b1;
                    end else begin
                        bus.b_out     <= ba_shreg[63:32];
                        bus.a_out     <= ba_shreg[31:0];
                        bus.op_out    <= cmd_op;
                        bus.out_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb_mtm_alu_deserializer: directed bench for mtm_alu_deserializer.
// Packets are serialised by tasks; the expected outcome of each command
// frame is queued when it is sent and popped by a monitor on the strobe.
module tb_mtm_alu_deserializer;
    import mtm_alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mtm_alu_deserializer_if bus ();

    mtm_alu_deserializer #(.DATA_FRAMES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          is_err;
        logic [2:0]  flags;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          strobes = 0;
    logic [31:0] held_a, held_b;
    logic [2:0]  held_op;

    // Independent CRC4 model: 5-bit shift with the full polynomial 10011.
    function automatic logic [3:0] crc_model(input logic [67:0] d);
        logic [4:0] c;
        c = '0;
        for (int i = 67; i >= 0; i--) begin
            c = {c[3:0], 1'b0};
            if (c[4] ^ d[i]) c = c ^ 5'b10011;
            c[4] = 1'b0;
        end
        return c[3:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_a  = '0;
            held_b  = '0;
            held_op = '0;
        end else if (bus.out_valid === 1'b1 || bus.err_out === 1'b1) begin
            strobes++;
            chk("strobe_exclusive", 64'(bus.out_valid & bus.err_out), 64'd0);
            chk("strobe_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("strobe_kind", {62'd0, bus.err_out, bus.out_valid},
                    e.is_err ? 64'd2 : 64'd1);
                if (e.is_err) begin
                    chk("err_flags", 64'(bus.err_flags), 64'(e.flags));
                    chk("a_hold", 64'(bus.a_out), 64'(held_a));
                    chk("b_hold", 64'(bus.b_out), 64'(held_b));
                    chk("op_hold", 64'(bus.op_out), 64'(held_op));
                end else begin
                    chk("a_out", 64'(bus.a_out), 64'(e.a));
                    chk("b_out", 64'(bus.b_out), 64'(e.b));
                    chk("op_out", 64'(bus.op_out), 64'(e.op));
                    chk("flags_idle", 64'(bus.err_flags), 64'd0);
                    held_a  = e.a;
                    held_b  = e.b;
                    held_op = e.op;
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.sin = b;
    endtask

    task automatic send_frame(input logic t, input logic [7:0] d, input logic stop, input int gap);
        send_bit(1'b0);
        send_bit(t);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
        for (int i = 0; i < gap; i++) send_bit(1'b1);
    endtask

    task automatic send_packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                               input int ndata, input bit force_crc, input logic [3:0] crc_f,
                               input int gap);
        logic [63:0] ba;
        logic [3:0]  good, crc;
        logic [7:0]  d;
        exp_t        e;
        ba   = {b, a};
        good = crc_model({b, a, 1'b1, op});
        crc  = force_crc ? crc_f : good;
        e.a = a; e.b = b; e.op = op; e.is_err = 1'b1; e.flags = 3'b000;
        if (ndata != 8)                                         e.flags = 3'b100;
        else if (crc != good)                                   e.flags = 3'b010;
        else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) e.flags = 3'b001;
        else                                                    e.is_err = 1'b0;
        for (int i = 0; i < ndata; i++) begin
            d = 8'hA5;
            if (i < 8) d = ba[63 - 8*i -: 8];
            send_frame(1'b0, d, 1'b1, gap);
        end
        exp_q.push_back(e);
        send_frame(1'b1, {1'b0, op, crc}, 1'b1, gap);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_a"}, 64'(bus.a_out), 64'd0);
        chk({tag, "_b"}, 64'(bus.b_out), 64'd0);
        chk({tag, "_op"}, 64'(bus.op_out), 64'd0);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_err"}, 64'(bus.err_out), 64'd0);
        chk({tag, "_flags"}, 64'(bus.err_flags), 64'd0);
    endtask

    initial begin
        int s0;
        bus.sin = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) send_bit(1'b1);

        // Zero operands, AND, literal CRC 1011.
        send_packet(32'h0, 32'h0, OP_AND, 8, 1'b1, 4'hB, 1);
        wait_drain("drain_zero_and");

        // Back-to-back frames, ADD.
        send_packet(32'h01020304, 32'h05060708, OP_ADD, 8, 1'b0, 4'h0, 0);
        wait_drain("drain_add_b2b");

        // Bad CRC 1010 on zero packet.
        send_packet(32'h0, 32'h0, OP_AND, 8, 1'b1, 4'hA, 1);
        wait_drain("drain_bad_crc");

        // Illegal opcode 010 with correct literal CRC 1101.
        send_packet(32'h0, 32'h0, 3'b010, 8, 1'b1, 4'hD, 1);
        wait_drain("drain_bad_op");

        // Short, long and empty packets.
        send_packet(32'h11223344, 32'h55667788, OP_OR, 7, 1'b0, 4'h0, 0);
        wait_drain("drain_short");
        send_packet(32'h11223344, 32'h55667788, OP_OR, 9, 1'b0, 4'h0, 0);
        wait_drain("drain_long");
        send_packet(32'h0, 32'h0, OP_AND, 0, 1'b1, 4'hB, 1);
        wait_drain("drain_empty");
        send_packet($urandom, $urandom, OP_SUB, 8, 1'b0, 4'h0, 0);
        wait_drain("drain_after_len");

        // Framing error in data frame 3, then line held low.
        send_frame(1'b0, 8'h12, 1'b1, 0);
        send_frame(1'b0, 8'h34, 1'b1, 0);
        exp_q.push_back('{is_err: 1'b1, flags: 3'b100, a: '0, b: '0, op: '0});
        send_frame(1'b0, 8'h56, 1'b0, 0);
        wait_drain("drain_framing");
        s0 = strobes;
        repeat (20) send_bit(1'b0);
        repeat (3) send_bit(1'b1);
        chk("no_strobe_while_low", 64'(strobes), 64'(s0));
        send_packet($urandom, $urandom, OP_OR, 8, 1'b0, 4'h0, 1);
        wait_drain("drain_after_framing");

        // Reset in the middle of a packet.
        for (int i = 0; i < 4; i++) send_frame(1'b0, 8'hC3, 1'b1, 0);
        send_bit(1'b0);
        s0 = strobes;
        rst_n   = 1'b0;
        bus.sin = 1'b1;
        repeat (2) @(negedge clk);
        chk_outputs_zero("mid_reset");
        rst_n = 1'b1;
        repeat (2) send_bit(1'b1);
        chk("no_strobe_reset", 64'(strobes), 64'(s0));
        send_packet($urandom, $urandom, OP_ADD, 8, 1'b0, 4'h0, 0);
        wait_drain("drain_after_reset");

        repeat (5) send_bit(1'b1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
